sequential_bcd_to_binary_converter: RTL

Converts a 4-digit packed BCD value (0000-9999) to unsigned binary by counting, not by arithmetic. It is the inverse of the team's sequential binary-to-BCD converter. A BCD counter and a binary counter advance together until the BCD counter equals the captured input; the binary count at that moment is the result. It sits between switch/BCD sources and binary datapath logic, and uses a start/busy/done handshake.

---
 rtl/sequential_bcd_to_binary_converter.sv | 113 +++++++++++
 1 files changed

// File: rtl/sequential_bcd_to_binary_converter.sv
// sequential_bcd_to_binary_converter: converts packed BCD to binary by running a decimal and a binary counter in lockstep.
// Optional invalid-digit rejection enabled by defining BCD_DIGIT_CHECK_EN.
module sequential_bcd_to_binary_converter #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    busy,
    output logic                    done,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    err
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam logic [BCD_W-1:0] BCD_MAX = {NUM_DIGITS{4'h9}};
    localparam logic [BIN_W-1:0] BIN_MAX = BIN_W'(10 ** NUM_DIGITS - 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_reg_q, bcd_reg_d;
    logic [BCD_W-1:0]   bcd_cnt_q, bcd_cnt_d;
    logic [BIN_W-1:0]   bin_cnt_q, bin_cnt_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               reject;

    function automatic logic [BCD_W-1:0] bcd_incr(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                c = (v[4*i +: 4] == 4'd9);
                r[4*i +: 4] = c ? 4'd0 : v[4*i +: 4] + 4'd1;
            end
        end
        return r;
    endfunction

`ifdef BCD_DIGIT_CHECK_EN
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) bad = bad | (v[4*i +: 4] > 4'd9);
        return bad;
    endfunction

    assign reject = has_bad_digit(bcd_in);
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bcd_reg_d = bcd_reg_q;
        bcd_cnt_d = bcd_cnt_q;
        bin_cnt_d = bin_cnt_q;
        bin_out_d = bin_out_q;
        done_d    = 1'b0;
        err_d     = err_q;
        if (state_q == IDLE) begin
            if (start && reject) begin
                err_d     = 1'b1;
                bin_out_d = '0;
                done_d    = 1'b1;
            end else if (start) begin
                bcd_reg_d = bcd_in;
                bcd_cnt_d = '0;
                bin_cnt_d = '0;
                err_d     = 1'b0;
                state_d   = COUNT;
            end
        end else if (bcd_cnt_q == bcd_reg_q || bcd_cnt_q == BCD_MAX) begin
            // An unmatched run ends at the top of the decimal range instead of wrapping.
            bin_out_d = (bcd_cnt_q == bcd_reg_q) ? bin_cnt_q : BIN_MAX;
            done_d    = 1'b1;
            state_d   = IDLE;
        end else begin
            bcd_cnt_d = bcd_incr(bcd_cnt_q);
            bin_cnt_d = bin_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bcd_reg_q <= '0;
            bcd_cnt_q <= '0;
            bin_cnt_q <= '0;
            bin_out_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_reg_q <= bcd_reg_d;
            bcd_cnt_q <= bcd_cnt_d;
            bin_cnt_q <= bin_cnt_d;
            bin_out_q <= bin_out_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q == COUNT);
    assign done    = done_q;
    assign bin_out = bin_out_q;
    assign err     = err_q;
endmodule
